// File: rtl/tick_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tick_meter
//  Description : Measures a tick stream synchronous to src_clk over fixed
//                windows of WINDOW samples. Reports the rising-edge count,
//                the number of high samples, and the shortest and longest
//                rise-to-rise spacing. Windows run back to back while enable
//                is high.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    src_clk     in   1      source clock, all logic on the rising edge
//    reset_n     in   1      asynchronous active-low reset
//    enable      in   1      1 = measure continuously, 0 = idle / abort
//    tick        in   1      tick under test, synchronous to src_clk
//    rise_count  out  CNT_W  rising edges in the last completed window
//    high_count  out  CNT_W  samples with tick==1 in the last completed window
//    period_min  out  CNT_W  shortest rise-to-rise spacing in cycles
//    period_max  out  CNT_W  longest rise-to-rise spacing in cycles
//    meas_valid  out  1      one-cycle pulse when the result outputs update
//    overflow    out  1      a counter saturated in the last completed window
//    stuck       out  1      the last completed window saw no rising edge
// ============================================================================
module tick_meter #(
  parameter int WINDOW = 1000,
  parameter int CNT_W  = 16
) (
  input  logic             src_clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             tick,
  output logic [CNT_W-1:0] rise_count,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max,
  output logic             meas_valid,
  output logic             overflow,
  output logic             stuck
);

  localparam int               WIN_W      = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] c_win_last = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] c_ones     = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_tick_q;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_rise;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;
  logic             r_seen;      // a rising edge has been seen this window
  logic             r_have_per;  // at least one full period has been recorded
  logic             r_ovf;

  // Accumulator base for the current sample: in REPORT the first sample of
  // the next window is taken, so it starts from cleared values.
  logic             w_clr;
  logic [CNT_W-1:0] w_b_high, w_b_rise, w_b_per, w_b_min, w_b_max;
  logic             w_b_seen, w_b_have, w_b_ovf;
  logic             w_edge;
  logic [CNT_W-1:0] w_high_nx, w_rise_nx, w_per_inc, w_per_nx, w_min_nx, w_max_nx;
  logic             w_seen_nx, w_have_nx, w_ovf_nx;

  always_comb begin
    w_clr    = (r_state == S_REPORT);
    w_b_high = w_clr ? '0     : r_high;
    w_b_rise = w_clr ? '0     : r_rise;
    w_b_per  = w_clr ? '0     : r_per;
    w_b_min  = w_clr ? c_ones : r_min;
    w_b_max  = w_clr ? '0     : r_max;
    w_b_seen = w_clr ? 1'b0   : r_seen;
    w_b_have = w_clr ? 1'b0   : r_have_per;
    w_b_ovf  = w_clr ? 1'b0   : r_ovf;

    w_edge = tick & ~r_tick_q;

    w_high_nx = w_b_high;
    if (tick && (w_b_high != c_ones)) w_high_nx = w_b_high + CNT_W'(1);
    w_rise_nx = w_b_rise;
    if (w_edge && (w_b_rise != c_ones)) w_rise_nx = w_b_rise + CNT_W'(1);

    // Spacing of the current rise = cycles counted since the previous one + 1
    w_per_inc = (w_b_per == c_ones) ? c_ones : (w_b_per + CNT_W'(1));
    w_per_nx  = w_per_inc;
    w_min_nx  = w_b_min;
    w_max_nx  = w_b_max;
    w_seen_nx = w_b_seen;
    w_have_nx = w_b_have;
    if (w_edge) begin
      w_per_nx  = '0;
      w_seen_nx = 1'b1;
      if (w_b_seen) begin
        w_have_nx = 1'b1;
        if (w_per_inc < w_b_min) w_min_nx = w_per_inc;
        if (w_per_inc > w_b_max) w_max_nx = w_per_inc;
      end
    end

    // The period counter only matters once a rise has anchored it.
    w_ovf_nx = w_b_ovf | (w_high_nx == c_ones) | (w_rise_nx == c_ones) |
               (w_b_seen & (w_per_inc == c_ones));
  end

  always_ff @(posedge src_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_tick_q   <= 1'b0;
      r_win_cnt  <= '0;
      r_high     <= '0;
      r_rise     <= '0;
      r_per      <= '0;
      r_min      <= c_ones;
      r_max      <= '0;
      r_seen     <= 1'b0;
      r_have_per <= 1'b0;
      r_ovf      <= 1'b0;
      rise_count <= '0;
      high_count <= '0;
      period_min <= '0;
      period_max <= '0;
      meas_valid <= 1'b0;
      overflow   <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) r_state <= S_ARM;
        end

        S_ARM: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else begin
            // Capturing tick here means a level already high is not an edge.
            r_tick_q   <= tick;
            r_win_cnt  <= '0;
            r_high     <= '0;
            r_rise     <= '0;
            r_per      <= '0;
            r_min      <= c_ones;
            r_max      <= '0;
            r_seen     <= 1'b0;
            r_have_per <= 1'b0;
            r_ovf      <= 1'b0;
            r_state    <= S_MEASURE;
          end
        end

        S_MEASURE: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else begin
            r_tick_q   <= tick;
            r_high     <= w_high_nx;
            r_rise     <= w_rise_nx;
            r_per      <= w_per_nx;
            r_min      <= w_min_nx;
            r_max      <= w_max_nx;
            r_seen     <= w_seen_nx;
            r_have_per <= w_have_nx;
            r_ovf      <= w_ovf_nx;
            if (r_win_cnt == c_win_last) begin
              // Results include this final sample and appear during REPORT.
              rise_count <= w_rise_nx;
              high_count <= w_high_nx;
              period_min <= w_have_nx ? w_min_nx : '0;
              period_max <= w_have_nx ? w_max_nx : '0;
              overflow   <= w_ovf_nx;
              stuck      <= (w_rise_nx == '0);
              meas_valid <= 1'b1;
              r_state    <= S_REPORT;
            end else begin
              r_win_cnt <= r_win_cnt + WIN_W'(1);
            end
          end
        end

        S_REPORT: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else begin
            // First sample of the next window; tick_q carries over so an edge
            // across the boundary lands in the new window.
            r_tick_q   <= tick;
            r_high     <= w_high_nx;
            r_rise     <= w_rise_nx;
            r_per      <= w_per_nx;
            r_min      <= w_min_nx;
            r_max      <= w_max_nx;
            r_seen     <= w_seen_nx;
            r_have_per <= w_have_nx;
            r_ovf      <= w_ovf_nx;
            r_win_cnt  <= WIN_W'(1);
            r_state    <= S_MEASURE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tick_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_meter
//  Description : Self-checking bench for tick_meter. A 16-bit and an 8-bit
//                instance share the stimulus; expected window results are
//                queued when a window is started and checked on meas_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_meter;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        tick;
  logic [15:0] rise_count, high_count, period_min, period_max;
  logic        meas_valid, overflow, stuck;
  logic [7:0]  rise8, high8, pmin8, pmax8;
  logic        valid8, ovf8, stuck8;

  tick_meter #(.WINDOW(1000), .CNT_W(16)) dut (
    .src_clk(clk), .reset_n(reset_n), .enable(enable), .tick(tick),
    .rise_count(rise_count), .high_count(high_count),
    .period_min(period_min), .period_max(period_max),
    .meas_valid(meas_valid), .overflow(overflow), .stuck(stuck)
  );

  tick_meter #(.WINDOW(1000), .CNT_W(8)) dut8 (
    .src_clk(clk), .reset_n(reset_n), .enable(enable), .tick(tick),
    .rise_count(rise8), .high_count(high8),
    .period_min(pmin8), .period_max(pmax8),
    .meas_valid(valid8), .overflow(ovf8), .stuck(stuck8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int per; int hi;
    int rise; int high; int pmin; int pmax; int stk; int ovf;
    int rise8; int high8; int pmin8; int pmax8; int ovf8;
  } vec_t;

  vec_t tbl [5];
  vec_t sb [$];
  vec_t mon_e;

  int total = 0;
  int bad   = 0;
  int pat_per = 50;
  int pat_hi  = 25;
  int ph      = 0;
  int n;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_pat(input int p, input int h);
    pat_per = p;
    pat_hi  = h;
    ph      = 0;
  endtask

  // One clock: tick driven on the falling edge, return just after the rise.
  task automatic step();
    @(negedge clk);
    tick = (ph < pat_hi);
    ph   = (ph + 1 >= pat_per) ? 0 : ph + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!meas_valid && cnt < 1200);
  endtask

  // Scoreboard: every meas_valid pops one expected window result.
  always @(posedge clk) begin
    #1;
    if (meas_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got 1 expected 0 (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("rise_count", int'(rise_count), mon_e.rise);
        chk("high_count", int'(high_count), mon_e.high);
        chk("period_min", int'(period_min), mon_e.pmin);
        chk("period_max", int'(period_max), mon_e.pmax);
        chk("stuck",      int'(stuck),      mon_e.stk);
        chk("overflow",   int'(overflow),   mon_e.ovf);
        chk("valid8",     int'(valid8),     1);
        chk("rise8",      int'(rise8),      mon_e.rise8);
        chk("high8",      int'(high8),      mon_e.high8);
        chk("pmin8",      int'(pmin8),      mon_e.pmin8);
        chk("pmax8",      int'(pmax8),      mon_e.pmax8);
        chk("stuck8",     int'(stuck8),     mon_e.stk);
        chk("ovf8",       int'(ovf8),       mon_e.ovf8);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           per hi  rise high pmin pmax stk ovf | rise8 high8 pmin8 pmax8 ovf8
    tbl[0] = '{50, 25,  20,  500, 50, 50, 0, 0,   20, 255, 50, 50, 1};
    tbl[1] = '{2,  1,   500, 500, 2,  2,  0, 0,   255, 255, 2, 2,  1};
    tbl[2] = '{20, 10,  50,  500, 20, 20, 0, 0,   50, 255, 20, 20, 1};
    tbl[3] = '{1,  1,   0,   1000, 0, 0,  1, 0,   0,  255, 0,  0,  1};
    tbl[4] = '{4,  1,   250, 250, 4,  4,  0, 0,   250, 250, 4, 4,  0};

    reset_n = 1'b0;
    enable  = 1'b0;
    tick    = 1'b0;
    set_pat(50, 25);
    repeat (3) step();
    chk("rst_rise",  int'(rise_count), 0);
    chk("rst_high",  int'(high_count), 0);
    chk("rst_pmin",  int'(period_min), 0);
    chk("rst_pmax",  int'(period_max), 0);
    chk("rst_valid", int'(meas_valid), 0);
    chk("rst_ovf",   int'(overflow),   0);
    chk("rst_stuck", int'(stuck),      0);
    reset_n = 1'b1;
    repeat (2) step();

    // Single windows from IDLE, one per table entry.
    for (int i = 0; i < 5; i++) begin
      set_pat(tbl[i].per, tbl[i].hi);
      repeat (3) step();
      sb.push_back(tbl[i]);
      enable = 1'b1;
      wait_valid(n);
      chk("latency", n, 1002);
      enable = 1'b0;
      repeat (5) step();
    end

    // Abort mid-window: no result, outputs hold the previous window.
    set_pat(50, 25);
    repeat (3) step();
    enable = 1'b1;
    repeat (402) step();
    enable = 1'b0;
    repeat (40) step();
    chk("hold_rise", int'(rise_count), tbl[4].rise);
    chk("hold_high", int'(high_count), tbl[4].high);
    chk("hold_pmin", int'(period_min), tbl[4].pmin);
    chk("hold_pmax", int'(period_max), tbl[4].pmax);
    chk("hold_stuck", int'(stuck),     tbl[4].stk);

    // Re-enable: full restart, then a gapless back-to-back window.
    sb.push_back(tbl[0]);
    sb.push_back(tbl[0]);
    enable = 1'b1;
    wait_valid(n);
    chk("restart_latency", n, 1002);
    wait_valid(n);
    chk("b2b_spacing", n, 1000);
    enable = 1'b0;
    repeat (5) step();

    // Reset mid-window: outputs clear at once, no result from that window.
    enable = 1'b1;
    repeat (500) step();
    reset_n = 1'b0;
    enable  = 1'b0;
    #2;
    chk("arst_rise",  int'(rise_count), 0);
    chk("arst_high",  int'(high_count), 0);
    chk("arst_pmin",  int'(period_min), 0);
    chk("arst_pmax",  int'(period_max), 0);
    chk("arst_valid", int'(meas_valid), 0);
    chk("arst_stuck", int'(stuck),      0);
    chk("arst_high8", int'(high8),      0);
    chk("arst_ovf8",  int'(ovf8),       0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (20) step();
    sb.push_back(tbl[0]);
    enable = 1'b1;
    wait_valid(n);
    chk("post_rst_latency", n, 1002);
    enable = 1'b0;
    repeat (5) step();

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
